// File: rtl/csr_port_arbiter_if.sv
// Bundle of the three requester handshakes and the shared CSR register-file port.
// Handshake: each req is held high until its one-cycle done pulse; the requester drops req in that done cycle.
interface csr_port_arbiter_if;
  logic        sw_req;
  logic [13:0] sw_addr;
  logic [31:0] sw_wmask;
  logic [31:0] sw_wdata;
  logic        sw_done;
  logic [31:0] sw_rdata;

  logic        exc_req;
  logic [6:0]  exc_code;
  logic [31:0] exc_pc;
  logic [31:0] exc_badv;
  logic        exc_badv_valid;
  logic        exc_done;

  logic        ertn_req;
  logic        ertn_done;
  logic [31:0] ertn_era;

  logic        busy;
  logic [13:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;

  modport master (
    output sw_req, sw_addr, sw_wmask, sw_wdata,
    output exc_req, exc_code, exc_pc, exc_badv, exc_badv_valid,
    output ertn_req, csr_rdata,
    input  sw_done, sw_rdata, exc_done, ertn_done, ertn_era,
    input  busy, csr_addr, csr_we, csr_wmask, csr_wdata
  );

  modport slave (
    input  sw_req, sw_addr, sw_wmask, sw_wdata,
    input  exc_req, exc_code, exc_pc, exc_badv, exc_badv_valid,
    input  ertn_req, csr_rdata,
    output sw_done, sw_rdata, exc_done, ertn_done, ertn_era,
    output busy, csr_addr, csr_we, csr_wmask, csr_wdata
  );
endinterface

// File: rtl/csr_port_arbiter.sv
// Serialises software CSR queries, exception entry and ertn restore onto one CSR port.
// Every output is registered: each transition loads the port values for the state being entered.
module csr_port_arbiter (
  input  logic                      clk,
  input  logic                      rst,
  csr_port_arbiter_if.slave         bus,
  output logic [3:0]                o_dbg_state
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    SW        = 4'd1,
    EXC_RD    = 4'd2,
    EXC_PRMD  = 4'd3,
    EXC_CRMD  = 4'd4,
    EXC_ERA   = 4'd5,
    EXC_ESTAT = 4'd6,
    EXC_BADV  = 4'd7,
    ERTN_RD   = 4'd8,
    ERTN_CRMD = 4'd9,
    ERTN_ERA  = 4'd10,
    DONE      = 4'd11
  } state_t;

  localparam logic [13:0] CSR_CRMD  = 14'h0;
  localparam logic [13:0] CSR_PRMD  = 14'h1;
  localparam logic [13:0] CSR_ESTAT = 14'h5;
  localparam logic [13:0] CSR_ERA   = 14'h6;
  localparam logic [13:0] CSR_BADV  = 14'h7;

  localparam logic [31:0] MASK_PLV_IE = 32'h0000_0007;
  localparam logic [31:0] MASK_ALL    = 32'hFFFF_FFFF;
  localparam logic [31:0] MASK_ECODE  = 32'h007F_0000;

  state_t      r_state;
  logic [6:0]  r_exc_code;
  logic [31:0] r_exc_pc;
  logic [31:0] r_exc_badv;
  logic        r_exc_badv_valid;

  logic        r_sw_done;
  logic [31:0] r_sw_rdata;
  logic        r_exc_done;
  logic        r_ertn_done;
  logic [31:0] r_ertn_era;
  logic        r_busy;
  logic [13:0] r_csr_addr;
  logic        r_csr_we;
  logic [31:0] r_csr_wmask;
  logic [31:0] r_csr_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_exc_code       <= '0;
      r_exc_pc         <= '0;
      r_exc_badv       <= '0;
      r_exc_badv_valid <= 1'b0;
      r_sw_done        <= 1'b0;
      r_sw_rdata       <= '0;
      r_exc_done       <= 1'b0;
      r_ertn_done      <= 1'b0;
      r_ertn_era       <= '0;
      r_busy           <= 1'b0;
      r_csr_addr       <= '0;
      r_csr_we         <= 1'b0;
      r_csr_wmask      <= '0;
      r_csr_wdata      <= '0;
    end else begin
      // Idle port values and no pulses unless the entered state says otherwise.
      r_sw_done   <= 1'b0;
      r_exc_done  <= 1'b0;
      r_ertn_done <= 1'b0;
      r_csr_addr  <= '0;
      r_csr_we    <= 1'b0;
      r_csr_wmask <= '0;
      r_csr_wdata <= '0;

      case (r_state)
        IDLE: begin
          if (bus.exc_req) begin
            r_state          <= EXC_RD;
            r_busy           <= 1'b1;
            r_exc_code       <= bus.exc_code;
            r_exc_pc         <= bus.exc_pc;
            r_exc_badv       <= bus.exc_badv;
            r_exc_badv_valid <= bus.exc_badv_valid;
            r_csr_addr       <= CSR_CRMD;
          end else if (bus.ertn_req) begin
            r_state    <= ERTN_RD;
            r_busy     <= 1'b1;
            r_csr_addr <= CSR_PRMD;
          end else if (bus.sw_req) begin
            r_state     <= SW;
            r_busy      <= 1'b1;
            r_csr_addr  <= bus.sw_addr;
            r_csr_we    <= |bus.sw_wmask;
            r_csr_wmask <= bus.sw_wmask;
            r_csr_wdata <= bus.sw_wdata;
          end
        end
        SW: begin
          r_state    <= DONE;
          r_sw_rdata <= bus.csr_rdata;
          r_sw_done  <= 1'b1;
        end
        EXC_RD: begin
          // The saved CRMD PLV/IE bits are held in the write-data register itself.
          r_state     <= EXC_PRMD;
          r_csr_addr  <= CSR_PRMD;
          r_csr_we    <= 1'b1;
          r_csr_wmask <= MASK_PLV_IE;
          r_csr_wdata <= {29'd0, bus.csr_rdata[2:0]};
        end
        EXC_PRMD: begin
          r_state     <= EXC_CRMD;
          r_csr_addr  <= CSR_CRMD;
          r_csr_we    <= 1'b1;
          r_csr_wmask <= MASK_PLV_IE;
        end
        EXC_CRMD: begin
          r_state     <= EXC_ERA;
          r_csr_addr  <= CSR_ERA;
          r_csr_we    <= 1'b1;
          r_csr_wmask <= MASK_ALL;
          r_csr_wdata <= r_exc_pc;
        end
        EXC_ERA: begin
          r_state     <= EXC_ESTAT;
          r_csr_addr  <= CSR_ESTAT;
          r_csr_we    <= 1'b1;
          r_csr_wmask <= MASK_ECODE;
          r_csr_wdata <= {9'd0, r_exc_code[6], r_exc_code[5:0], 16'd0};
        end
        EXC_ESTAT: begin
          if (r_exc_badv_valid) begin
            r_state     <= EXC_BADV;
            r_csr_addr  <= CSR_BADV;
            r_csr_we    <= 1'b1;
            r_csr_wmask <= MASK_ALL;
            r_csr_wdata <= r_exc_badv;
          end else begin
            r_state    <= DONE;
            r_exc_done <= 1'b1;
          end
        end
        EXC_BADV: begin
          r_state    <= DONE;
          r_exc_done <= 1'b1;
        end
        ERTN_RD: begin
          r_state     <= ERTN_CRMD;
          r_csr_addr  <= CSR_CRMD;
          r_csr_we    <= 1'b1;
          r_csr_wmask <= MASK_PLV_IE;
          r_csr_wdata <= {29'd0, bus.csr_rdata[2:0]};
        end
        ERTN_CRMD: begin
          r_state    <= ERTN_ERA;
          r_csr_addr <= CSR_ERA;
        end
        ERTN_ERA: begin
          r_state     <= DONE;
          r_ertn_era  <= bus.csr_rdata;
          r_ertn_done <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sw_done   = r_sw_done;
  assign bus.sw_rdata  = r_sw_rdata;
  assign bus.exc_done  = r_exc_done;
  assign bus.ertn_done = r_ertn_done;
  assign bus.ertn_era  = r_ertn_era;
  assign bus.busy      = r_busy;
  assign bus.csr_addr  = r_csr_addr;
  assign bus.csr_we    = r_csr_we;
  assign bus.csr_wmask = r_csr_wmask;
  assign bus.csr_wdata = r_csr_wdata;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_csr_port_arbiter.sv
// Directed bench for csr_port_arbiter with a small CSR register file hung off the shared port.
module tb_csr_port_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] dbg_state;
  int         checks;
  int         errors;

  logic [31:0] mem [0:7];
  logic        poke_en;
  logic [2:0]  poke_addr;
  logic [31:0] poke_data;

  logic [1:0]  exp_q[$];

  csr_port_arbiter_if bus ();

  csr_port_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- CSR register file (writes blocked while rst is high) ----------------
  assign bus.csr_rdata = (bus.csr_addr < 14'd8) ? mem[bus.csr_addr[2:0]] : 32'h0;

  always @(posedge clk) begin
    if (poke_en)
      mem[poke_addr] <= poke_data;
    else if (!rst && bus.csr_we && bus.csr_addr < 14'd8)
      mem[bus.csr_addr[2:0]] <= (mem[bus.csr_addr[2:0]] & ~bus.csr_wmask) |
                                (bus.csr_wdata & bus.csr_wmask);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic poke(input logic [2:0] a, input logic [31:0] d);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = d;
    tick();
    poke_en   = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // sel: 1 = exc, 2 = ertn, 3 = sw. Counts negedges from the request until its done pulse.
  task automatic wait_done(input int sel, input int limit, output int cyc, output logic we_seen);
    logic d;
    cyc     = 0;
    we_seen = 1'b0;
    d       = 1'b0;
    while (!d && cyc < limit) begin
      tick();
      cyc++;
      if (bus.csr_we) we_seen = 1'b1;
      case (sel)
        1:       d = bus.exc_done;
        2:       d = bus.ertn_done;
        default: d = bus.sw_done;
      endcase
    end
  endtask

  // ---------------- stimulus + checks ----------------
  initial begin
    int          cyc;
    logic        we_seen;
    int          n_done, n_exc, n_ertn, n_sw, idle_cnt;
    int          c_exc, c_ertn, c_sw;
    logic [31:0] era_seen, rdata_seen;
    logic [1:0]  got_code;

    checks = 0; errors = 0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    bus.sw_req = 1'b0; bus.sw_addr = '0; bus.sw_wmask = '0; bus.sw_wdata = '0;
    bus.exc_req = 1'b0; bus.exc_code = '0; bus.exc_pc = '0; bus.exc_badv = '0;
    bus.exc_badv_valid = 1'b0; bus.ertn_req = 1'b0;
    rst = 1'b1;
    repeat (3) tick();

    // reset state
    check("rst_busy", {31'd0, bus.busy}, 32'h0);
    check("rst_we", {31'd0, bus.csr_we}, 32'h0);
    check("rst_addr", {18'd0, bus.csr_addr}, 32'h0);
    check("rst_done", {29'd0, bus.sw_done, bus.exc_done, bus.ertn_done}, 32'h0);
    check("rst_state", {28'd0, dbg_state}, 32'h0);
    rst = 1'b0;
    tick();

    // SW read of ERA, no write
    poke(3'd6, 32'h1C00_0010);
    bus.sw_req = 1'b1; bus.sw_addr = 14'h6; bus.sw_wmask = 32'h0; bus.sw_wdata = 32'hFFFF_FFFF;
    wait_done(3, 10, cyc, we_seen);
    check("sw_latency", cyc, 32'd2);
    check("sw_we_never", {31'd0, we_seen}, 32'h0);
    check("sw_rdata", bus.sw_rdata, 32'h1C00_0010);
    bus.sw_req = 1'b0;
    tick();
    check("sw_idle_after", {30'd0, bus.busy, bus.sw_done}, 32'h0);
    check("sw_era_kept", mem[6], 32'h1C00_0010);

    // exception entry without BADV
    poke(3'd0, 32'h0000_00AF);
    poke(3'd1, 32'h0000_00F0);
    poke(3'd5, 32'hFF80_FFFF);
    poke(3'd7, 32'h1111_2222);
    bus.exc_req = 1'b1; bus.exc_code = 7'h0B; bus.exc_pc = 32'h8000_1234;
    bus.exc_badv = 32'h5555_5555; bus.exc_badv_valid = 1'b0;
    wait_done(1, 20, cyc, we_seen);
    check("exc_latency", cyc, 32'd6);
    bus.exc_req = 1'b0; bus.exc_code = '0; bus.exc_pc = '0;
    tick();
    check("exc_prmd", mem[1], 32'h0000_00F7);
    check("exc_crmd", mem[0], 32'h0000_00A8);
    check("exc_era", mem[6], 32'h8000_1234);
    check("exc_estat", mem[5], 32'hFF8B_FFFF);
    check("exc_badv_kept", mem[7], 32'h1111_2222);

    // exception entry with BADV, EsubCode bit set
    poke(3'd5, 32'h0);
    poke(3'd7, 32'h0);
    bus.exc_req = 1'b1; bus.exc_code = 7'h48; bus.exc_pc = 32'h0000_4000;
    bus.exc_badv = 32'hDEAD_BEE0; bus.exc_badv_valid = 1'b1;
    wait_done(1, 20, cyc, we_seen);
    check("excb_latency", cyc, 32'd7);
    bus.exc_req = 1'b0; bus.exc_badv_valid = 1'b0;
    tick();
    check("excb_estat", mem[5], 32'h0048_0000);
    check("excb_badv", mem[7], 32'hDEAD_BEE0);

    // ertn restore
    poke(3'd1, 32'h0000_0005);
    poke(3'd6, 32'h1C00_2000);
    poke(3'd0, 32'h0000_0018);
    bus.ertn_req = 1'b1;
    wait_done(2, 20, cyc, we_seen);
    check("ertn_latency", cyc, 32'd4);
    check("ertn_era", bus.ertn_era, 32'h1C00_2000);
    bus.ertn_req = 1'b0;
    tick();
    check("ertn_crmd", mem[0], 32'h0000_001D);

    // simultaneous requests: exc, then ertn, then sw
    poke(3'd0, 32'h3);
    poke(3'd1, 32'h0);
    poke(3'd5, 32'h0);
    poke(3'd6, 32'h0);
    poke(3'd7, 32'hAAAA_5555);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    bus.exc_req = 1'b1; bus.exc_code = 7'h01; bus.exc_pc = 32'h100; bus.exc_badv_valid = 1'b0;
    bus.ertn_req = 1'b1;
    bus.sw_req = 1'b1; bus.sw_addr = 14'h7; bus.sw_wmask = 32'h0000_FFFF; bus.sw_wdata = 32'h1234_5678;
    n_done = 0; n_exc = 0; n_ertn = 0; n_sw = 0; idle_cnt = 0;
    c_exc = 0; c_ertn = 0; c_sw = 0; era_seen = '0; rdata_seen = '0;
    for (int c = 1; c <= 22; c++) begin
      tick();
      got_code = 2'd0;
      if (bus.exc_done) begin
        got_code = 2'd1; n_exc++; c_exc = c; bus.exc_req = 1'b0;
      end
      if (bus.ertn_done) begin
        got_code = 2'd2; n_ertn++; c_ertn = c; era_seen = bus.ertn_era; bus.ertn_req = 1'b0;
      end
      if (bus.sw_done) begin
        got_code = 2'd3; n_sw++; c_sw = c; rdata_seen = bus.sw_rdata; bus.sw_req = 1'b0;
      end
      if (got_code != 2'd0) begin
        n_done++;
        if (exp_q.size() > 0) check("arb_order", {30'd0, got_code}, {30'd0, exp_q.pop_front()});
      end
      if (!bus.busy && n_exc > 0 && n_sw == 0) idle_cnt++;
    end
    check("arb_n_done", n_done, 32'd3);
    check("arb_pulses", {n_exc[7:0], n_ertn[7:0], n_sw[7:0]}, 32'h0001_0101);
    check("arb_exc_cyc", c_exc, 32'd6);
    check("arb_ertn_cyc", c_ertn, 32'd11);
    check("arb_sw_cyc", c_sw, 32'd14);
    check("arb_idle_gaps", idle_cnt, 32'd2);
    check("arb_ertn_era", era_seen, 32'h0000_0100);
    check("arb_sw_rdata", rdata_seen, 32'hAAAA_5555);
    check("arb_crmd", mem[0], 32'h3);
    check("arb_badv", mem[7], 32'hAAAA_5678);
    check("arb_q_empty", exp_q.size(), 32'd0);

    // reset while in EXC_ERA
    poke(3'd0, 32'h6);
    poke(3'd1, 32'h0);
    poke(3'd6, 32'h5A5A_5A5A);
    bus.exc_req = 1'b1; bus.exc_code = 7'h03; bus.exc_pc = 32'h999; bus.exc_badv_valid = 1'b0;
    cyc = 0;
    while (dbg_state != 4'd5 && cyc < 10) begin
      tick();
      cyc++;
    end
    check("rstm_reach_era", cyc, 32'd4);
    rst = 1'b1;
    bus.exc_req = 1'b0;
    tick();
    check("rstm_busy", {31'd0, bus.busy}, 32'h0);
    check("rstm_port", {bus.csr_we, 3'd0, bus.csr_addr, 14'd0}, 32'h0);
    check("rstm_wmask", bus.csr_wmask, 32'h0);
    check("rstm_wdata", bus.csr_wdata, 32'h0);
    check("rstm_state", {28'd0, dbg_state}, 32'h0);
    rst = 1'b0;
    n_exc = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.exc_done) n_exc++;
      tick();
    end
    check("rstm_no_done", n_exc, 32'd0);
    check("rstm_prmd", mem[1], 32'h6);
    check("rstm_crmd", mem[0], 32'h0);
    check("rstm_era", mem[6], 32'h5A5A_5A5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_port_arbiter.md
# csr_port_arbiter

Shares the single CSR register-file port among three requesters:
- the privileged execution unit (software `csrrd`/`csrwr`/`csrxchg` queries);
- the exception commit logic (hardware exception entry);
- the `ertn` restore path.

Hardware sequences are multi-cycle read-modify-write chains on CRMD/PRMD/ERA/ESTAT/BADV. The arbiter serialises them onto one address/mask/data port and returns completion pulses to each requester.

## Interface
- `clk`  in  1  clock
- `rst`  in  1  synchronous reset, active-high
- `sw_req`  in  1  software CSR query; held high until `sw_done`
- `sw_addr`  in  14  CSR number
- `sw_wmask`  in  32  bit write enable; 0 = read only
- `sw_wdata`  in  32  write data
- `sw_done`  out  1  one-cycle completion pulse
- `sw_rdata`  out  32  old CSR value, valid while `sw_done`
- `exc_req`  in  1  exception entry; held until `exc_done`
- `exc_code`  in  7  bits [5:0] Ecode, bit [6] EsubCode[0]
- `exc_pc`  in  32  faulting PC, written to ERA
- `exc_badv`  in  32  bad virtual address
- `exc_badv_valid`  in  1  write BADV
- `exc_done`  out  1  one-cycle pulse
- `ertn_req`  in  1  exception return; held until `ertn_done`
- `ertn_done`  out  1  one-cycle pulse
- `ertn_era`  out  32  ERA value, valid while `ertn_done`
- `busy`  out  1  high in every non-IDLE state
- `csr_addr`  out  14  port address
- `csr_we`  out  1  port write strobe
- `csr_wmask`  out  32  port bit write enable
- `csr_wdata`  out  32  port write data
- `csr_rdata`  in  32  combinational read of `csr_addr`; read-first within the cycle

CSR numbers: CRMD 0x0, PRMD 0x1, ESTAT 0x5, ERA 0x6, BADV 0x7.

## Operation
- FSM states: IDLE, SW, EXC_RD, EXC_PRMD, EXC_CRMD, EXC_ERA, EXC_ESTAT, EXC_BADV, ERTN_RD, ERTN_CRMD, ERTN_ERA, DONE.
- **Arbitration:** from IDLE only, fixed priority exc > ertn > sw. Non-preemptive: a started sequence always completes.
- **SW:**
  - drive `sw_addr`, `csr_we`=|`sw_wmask`, `sw_wmask`, `sw_wdata`;
  - latch `csr_rdata` into `sw_rdata`;
  - go to DONE.
- **EXC_RD:** `csr_addr`=CRMD, no write; latch `csr_rdata[2:0]` into `saved_crmd`.
- **EXC_PRMD:** write PRMD, mask 0x7, data `saved_crmd`.
- **EXC_CRMD:** write CRMD, mask 0x7, data 0 (PLV=0, IE=0).
- **EXC_ERA:** write ERA, mask all-ones, data `exc_pc`.
- **EXC_ESTAT:**
  - write ESTAT, mask 0x007F_0000;
  - data: `exc_code[5:0]` at bits [21:16], `exc_code[6]` at bit 22.
  - Next state is EXC_BADV if `exc_badv_valid`, else DONE.
- **EXC_BADV:** write BADV, mask all-ones, data `exc_badv`.
- **ERTN_RD:** read PRMD; latch `csr_rdata[2:0]`.
- **ERTN_CRMD:** write CRMD, mask 0x7, data = latched PRMD bits.
- **ERTN_ERA:** read ERA; latch into `ertn_era`.
- **Input sampling:**
  - Exception inputs are sampled into internal registers in the IDLE→EXC_RD cycle.
  - SW inputs are used directly; the requester holds them stable until `sw_done`.
- **DONE:**
  - pulse the done output of the owning requester;
  - `csr_we`=0;
  - next state IDLE unconditionally; requests are not sampled in DONE.
  - Requester drops its `req` in the done cycle; a request still high in IDLE is a new request.
- **Port outputs:**
  - `csr_we` is low in every read-only state and in IDLE/DONE.
  - `csr_addr`/`csr_wmask`/`csr_wdata` are 0 in IDLE/DONE.

## Timing
- All outputs are registered.
- Reset value of every output is 0; FSM goes to IDLE; internal latches are cleared.
- Latency from request sampled in IDLE to done pulse:
  - SW: 2 cycles;
  - EXC: 6 cycles without BADV, 7 with BADV;
  - ERTN: 4 cycles.
- Simultaneous requests: winner by priority. Losers remain pending and are served after the winner's DONE → IDLE. Back-to-back requests are therefore separated by at least one IDLE cycle.
- `exc_req` rising during a SW or ERTN sequence waits; it does not abort the sequence.
- Reset mid-sequence:
  - return to IDLE next edge; no done pulse;
  - writes already committed to the CSR file are not undone.

## Test plan
- Reset, then `sw_req` with addr 0x6, mask 0, CSR ERA=0x1C00_0010 → `csr_we`=0 for the whole sequence; `sw_done` 2 cycles later with `sw_rdata`=0x1C00_0010.
- CRMD=0x7, `exc_req` with code 0x0B, pc 0x8000_1234, `exc_badv_valid`=0 → PRMD[2:0]=7, CRMD[2:0]=0, ERA=0x8000_1234, ESTAT[22:16]=0x0B; BADV unchanged; `exc_done` at cycle 6.
- `exc_badv_valid`=1, badv 0xDEAD_BEE0, code 0x48 → ESTAT[21:16]=0x08 and ESTAT[22]=1; BADV=0xDEAD_BEE0; `exc_done` at cycle 7.
- PRMD=0x5, ERA=0x1C00_2000, `ertn_req` → CRMD[2:0]=5; `ertn_done` at cycle 4 with `ertn_era`=0x1C00_2000.
- `sw_req`, `ertn_req` and `exc_req` asserted in the same cycle → exception served first, then ertn, then sw; exactly one IDLE cycle between sequences; one done pulse each.
- `rst` asserted during EXC_ERA → next cycle all outputs 0 and `busy`=0; no `exc_done`; PRMD and CRMD updates persist, ERA unchanged.
